key_conditioner: RTL and testbench



---
 rtl/key_pkg.sv | 18 +
 rtl/key_debounce_ch.sv | 126 ++++++++++++
 rtl/key_conditioner.sv | 68 ++++++
 tb/tb_key_conditioner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and sizing helpers for the key conditioner
// Purpose: per-channel debounce state encoding and counter-width helpers
//   used by key_conditioner and key_debounce_ch.
// Ports: none (package).
package key_pkg;

  typedef enum logic [1:0] {KS_IDLE, KS_ARM, KS_HELD, KS_DISARM} key_state_t;

  // Bits needed to hold values 0..n inclusive (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one push-button channel: synchroniser, debounce FSM, strobes
// Purpose: synchronise one active-low key, accept a new level only after it has
//   been stable long enough, and pulse press/release for one cycle on acceptance.
//   With KEY_REPEAT_EN defined, a held key also emits auto-repeat press pulses.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   key_n          in   raw key, active-low, asynchronous
//   level          out  debounced level, 1 = pressed
//   press_pulse    out  one-cycle strobe on accepted press (and auto-repeat)
//   release_pulse  out  one-cycle strobe on accepted release
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_ALLOWED  = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic sync1, sync2, s;
  key_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic accept_press, accept_release, repeat_fire;

  // Synchroniser flops idle at 1 so a reset always looks like "released".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  always_comb begin
    state_nx       = state;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    cnt_nx         = cnt;
    case (state)
      KS_IDLE:   if (s) state_nx = KS_ARM;
      KS_ARM: begin
        if (!s) begin
          state_nx = KS_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx     = KS_HELD;
          accept_press = 1'b1;
        end
      end
      KS_HELD:   if (!s) state_nx = KS_DISARM;
      KS_DISARM: begin
        if (s) begin
          state_nx = KS_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx       = KS_IDLE;
          accept_release = 1'b1;
        end
      end
      default:   state_nx = KS_IDLE;
    endcase
    // Counter measures time in the current state; it saturates rather than wrapping.
    if (state_nx != state) cnt_nx = '0;
    else if (cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= KS_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      press_pulse   <= accept_press | repeat_fire;
      release_pulse <= accept_release;
    end
  end

  assign level = (state == KS_HELD) || (state == KS_DISARM);

`ifdef KEY_REPEAT_EN
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  logic [RW-1:0] rpt_cnt;

  // Fires only while staying in HELD; a bounce into DISARM suppresses it.
  assign repeat_fire = REPEAT_ALLOWED && (state == KS_HELD) &&
                       (state_nx == KS_HELD) && (rpt_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else if (accept_press) begin
      rpt_cnt <= RW'(REPEAT_DELAY - 1);
    end else if ((state == KS_DISARM) && (state_nx == KS_HELD)) begin
      rpt_cnt <= RW'(REPEAT_PERIOD - 1);
    end else if (repeat_fire) begin
      rpt_cnt <= RW'(REPEAT_PERIOD - 1);
    end else if ((state == KS_HELD) && (rpt_cnt != '0)) begin
      rpt_cnt <= rpt_cnt - 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N-channel push-button conditioner with stretched system reset
// Purpose: debounce NUM_KEYS active-low keys into clean levels and press/release
//   strobes, and derive sys_reset from the reset input and key RESET_KEY.
//   Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   KEY          in   raw keys, active-low, asynchronous
//   key_level    out  debounced levels, 1 = pressed
//   key_press    out  one-cycle press strobes (and auto-repeat)
//   key_release  out  one-cycle release strobes
//   sys_reset    out  active-high reset, deasserts synchronously after stretch
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_KEY       = 0,
  parameter int RESET_STRETCH   = 16,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                sys_reset
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_ALLOWED (i != RESET_KEY)
`endif
    ) u_ch (
      .clk          (CLOCK_50),
      .rst          (reset),
      .key_n        (KEY[i]),
      .level        (key_level[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i])
    );
  end

  localparam int SW = cnt_width(RESET_STRETCH);

  logic [SW-1:0] stretch_cnt;

  // Reloaded while any source is active, so the stretch restarts on each clear.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      stretch_cnt <= SW'(RESET_STRETCH);
    end else if (key_level[RESET_KEY]) begin
      stretch_cnt <= SW'(RESET_STRETCH);
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - 1'b1;
    end
  end

  assign sys_reset = key_level[RESET_KEY] | (stretch_cnt != '0);

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int D  = 8;
  localparam int RK = 0;
  localparam int RS = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [NK-1:0] KEY;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          sys_reset;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .RESET_KEY(RK),
    .RESET_STRETCH(RS), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .sys_reset(sys_reset)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int press_ev[NK][$];
  int rel_ev[NK][$];

  // Reference model: raw KEY samples, the pressed-view history, expected outputs.
  bit [NK-1:0] kq[$];
  bit [NK-1:0] sh[$];
  bit [NK-1:0] lvl, prs, rel, s_prev;
  bit          sysr;
  int          since;
  int          anchor[NK];
  bit          anchor_acc[NK];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_events(input string nm, input int got[$], input int exp[$]);
    bit ok;
    ok = (got.size() == exp.size());
    if (ok) foreach (exp[j]) if (got[j] != exp[j]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%p expected=%p", nm, got, exp);
    end
  endtask

  // Level flips once the last D+1 synchronised samples all disagree with it;
  // the synchronised view lags the KEY samples by two edges.
  task automatic model_step();
    bit [NK-1:0] s_now, lvl_pre;
    bit flip;
    int d;
    if (reset) begin
      kq.delete(); sh.delete();
      lvl = '0; prs = '0; rel = '0; s_prev = '0;
      since = 0; sysr = 1'b1;
      for (int i = 0; i < NK; i++) begin anchor[i] = 0; anchor_acc[i] = 1'b0; end
      return;
    end
    lvl_pre = lvl;
    s_now = (kq.size() >= 2) ? ~kq[kq.size()-2] : '0;
    kq.push_back(KEY);
    if (kq.size() > 4) void'(kq.pop_front());
    sh.push_back(s_now);
    if (sh.size() > D + 1) void'(sh.pop_front());
    prs = '0; rel = '0;
    for (int i = 0; i < NK; i++) begin
      flip = (sh.size() == D + 1);
      foreach (sh[j]) if (sh[j][i] == lvl_pre[i]) flip = 1'b0;
      if (flip) begin
        lvl[i] = ~lvl_pre[i];
        if (lvl[i]) begin
          prs[i] = 1'b1; anchor[i] = cyc; anchor_acc[i] = 1'b1;
        end else begin
          rel[i] = 1'b1;
        end
      end
`ifdef KEY_REPEAT_EN
      else if (lvl_pre[i] && s_now[i] && !s_prev[i]) begin
        anchor[i] = cyc; anchor_acc[i] = 1'b0;
      end else if (lvl_pre[i] && s_now[i] && s_prev[i] && i != RK) begin
        d = cyc - anchor[i];
        if (anchor_acc[i]) prs[i] = (d >= RD) && ((d - RD) % RP == 0);
        else               prs[i] = (d > 0) && (d % RP == 0);
      end
`endif
    end
    s_prev = s_now;
    if (lvl_pre[RK]) since = 0;
    else if (since < 1000) since++;
    sysr = lvl[RK] || (since < RS);
  endtask

  initial begin
    forever begin
      @(posedge CLOCK_50);
      cyc++;
      model_step();
      #1;
      chk("key_level", key_level, lvl);
      chk("key_press", key_press, prs);
      chk("key_release", key_release, rel);
      chk("sys_reset", sys_reset, sysr);
      for (int i = 0; i < NK; i++) begin
        if (key_press[i]) press_ev[i].push_back(cyc);
        if (key_release[i]) rel_ev[i].push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge CLOCK_50);
  endtask

  task automatic clear_ev();
    for (int i = 0; i < NK; i++) begin press_ev[i].delete(); rel_ev[i].delete(); end
  endtask

  int f, r, p, g;
  int exp_q[$];
  int empty_q[$];
  int hold[NK];
  int rst_hold;

  initial begin
    reset = 1'b1;
    KEY   = '1;
    // 1: reset and stretch
    repeat (3) @(negedge CLOCK_50);
    chk("reset_level", key_level, 0);
    chk("reset_sys", sys_reset, 1);
    reset = 1'b0;
    p = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      wait_edge(p + k);
      chk("stretch", sys_reset, (k < 3) ? 1 : 0);
    end
    wait_edge(p + 6);

    // 2: clean press/release on KEY[1]
    clear_ev();
    KEY[1] = 1'b0; f = cyc + 1;
    wait_edge(f + 19);
    KEY[1] = 1'b1; r = cyc + 1;
    wait_edge(r + 15);
    exp_q = '{f + 10}; chk_events("t2_press", press_ev[1], exp_q);
    exp_q = '{r + 10}; chk_events("t2_release", rel_ev[1], exp_q);

    // 3: bouncing KEY[2]
    clear_ev();
    for (int k = 0; k < 10; k++) begin
      KEY[2] = k[0];
      repeat (3) @(negedge CLOCK_50);
    end
    KEY[2] = 1'b0; f = cyc + 1;
    wait_edge(f + 14);
    exp_q = '{f + 10}; chk_events("t3_press", press_ev[2], exp_q);
    chk_events("t3_release", rel_ev[2], empty_q);
    KEY[2] = 1'b1;
    wait_edge(f + 30);

    // 4: short glitch on KEY[3]
    clear_ev();
    KEY[3] = 1'b0;
    repeat (7) @(negedge CLOCK_50);
    KEY[3] = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    chk_events("t4_press", press_ev[3], empty_q);
    chk("t4_level", key_level[3], 0);
    chk_events("t4_other", press_ev[1], empty_q);

    // 5: reset key drives sys_reset
    clear_ev();
    KEY[0] = 1'b0; f = cyc + 1;
    wait_edge(f + 9);  chk("t5_sys_before", sys_reset, 0);
    wait_edge(f + 10); chk("t5_sys_on", sys_reset, 1);
    wait_edge(f + 14); KEY[0] = 1'b1;
    wait_edge(f + 28); chk("t5_sys_hold", sys_reset, 1);
    wait_edge(f + 29); chk("t5_sys_off", sys_reset, 0);
    exp_q = '{f + 25}; chk_events("t5_release", rel_ev[0], exp_q);
    wait_edge(f + 35);

    // 6a: long hold on KEY[1]
    clear_ev();
    KEY[1] = 1'b0; f = cyc + 1;
    wait_edge(f + 49);
    KEY[1] = 1'b1;
    wait_edge(f + 65);
`ifdef KEY_REPEAT_EN
    exp_q = '{f + 10, f + 30, f + 35, f + 40, f + 45, f + 50};
`else
    exp_q = '{f + 10};
`endif
    chk_events("t6_press", press_ev[1], exp_q);
    exp_q = '{f + 60}; chk_events("t6_release", rel_ev[1], exp_q);

    // 6b: reset while held; key must re-debounce
    clear_ev();
    KEY[1] = 1'b0; f = cyc + 1;
    wait_edge(f + 32);
    reset = 1'b1;
    #1;
    chk("t6_rst_level", key_level, 0);
    chk("t6_rst_press", key_press, 0);
    chk("t6_rst_sys", sys_reset, 1);
    wait_edge(f + 35);
    reset = 1'b0; g = cyc + 1;
    wait_edge(g + 15);
    KEY[1] = 1'b1;
    wait_edge(g + 30);
`ifdef KEY_REPEAT_EN
    exp_q = '{f + 10, f + 30, g + 10};
`else
    exp_q = '{f + 10, g + 10};
`endif
    chk_events("t6_redebounce", press_ev[1], exp_q);

    // Random phase: mixed bounce, accepted holds, long holds and resets
    for (int i = 0; i < NK; i++) hold[i] = $urandom_range(1, 12);
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLOCK_50);
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          KEY[i] = ~KEY[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 12);
        end else begin
          hold[i]--;
        end
      end
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 499) == 0) rst_hold = $urandom_range(1, 3);
      reset = (rst_hold > 0);
    end
    reset = 1'b0;
    KEY = '1;
    repeat (40) @(negedge CLOCK_50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
